uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_periph.sv | 156 +++++++++++++++
 tb/tb_uart_tx_periph.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and status-word layout for the UART transmit peripheral.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // Status exposes only a 4-bit count; deeper FIFOs read back as 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, dout shows the head combinationally (zero-latency read).
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: CPU stores queue bytes, FSM serialises 8N1 LSB first.
// First start bit appears two edges after the store; frames run back-to-back while queued.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 10416,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_ADDR      = 32'd12,
    parameter logic [31:0] STAT_ADDR    = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] write_direction,
    input  logic [31:0] data_out1,
    input  logic [1:0]  MemWrite,
    output logic [31:0] data_in,
    output logic        tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t      state;
    tx_state_t      state_nxt;
    logic [BW-1:0]  baud_cnt;
    logic [BW-1:0]  baud_nxt;
    logic [2:0]     bit_idx;
    logic [2:0]     idx_nxt;
    logic [7:0]     shreg;
    logic           tx_nxt;
    logic           baud_done;
    logic           overflow;

    logic           wr_tx;
    logic           wr_stat;
    logic           ovf_event;
    logic           fifo_push;
    logic           fifo_pop;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_hi;

    assign unused_hi = ^data_out1[31:8];

    assign wr_tx     = (MemWrite != 2'b00) && (write_direction == TX_ADDR);
    assign wr_stat   = (MemWrite != 2'b00) && (write_direction == STAT_ADDR);
    assign fifo_push = wr_tx;
    assign ovf_event = wr_tx && fifo_full && !fifo_pop;
    assign baud_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign tx_busy   = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_out1[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        baud_nxt  = BW'(baud_cnt + 1'b1);
        idx_nxt   = bit_idx;
        fifo_pop  = 1'b0;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_nxt = 1'b0;
                if (baud_done) begin
                    baud_nxt  = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_nxt = shreg[bit_idx];
                if (baud_done) begin
                    baud_nxt = '0;
                    idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (baud_done) begin
                    baud_nxt = '0;
                    // Chain straight into the next start bit so queued frames abut.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= idx_nxt;
            tx       <= tx_nxt;
            if (fifo_pop) begin
                shreg <= fifo_dout;
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (wr_stat) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        data_in = '0;
        if (write_direction == STAT_ADDR) begin
            data_in[STAT_BUSY]             = tx_busy;
            data_in[STAT_FULL]             = fifo_full;
            data_in[STAT_EMPTY]            = fifo_empty;
            data_in[STAT_OVF]              = overflow;
            data_in[STAT_CNT_LSB +: 4]     = sat_count(32'(fifo_count));
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_periph;

    localparam logic [31:0] TXA = 32'd12;
    localparam logic [31:0] STA = 32'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] write_direction;
    logic [31:0] data_out1;
    logic [1:0]  MemWrite;
    logic [31:0] data_in;
    logic        tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;
    int tx_falls = 0;
    logic tx_prev = 1'b1;

    uart_tx_periph #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (TXA),
        .STAT_ADDR    (STA)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_direction (write_direction),
        .data_out1       (data_out1),
        .MemWrite        (MemWrite),
        .data_in         (data_in),
        .tx              (tx),
        .tx_busy         (tx_busy)
    );

    always #5 clk = ~clk;

    // Start bits are the only falling edges when every payload byte is 0xFF.
    always @(negedge clk) begin
        if (tx_prev === 1'b1 && tx === 1'b0) tx_falls++;
        tx_prev = tx;
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 2'b01;
        write_direction = a;
        data_out1 = d;
        @(posedge clk);
        #1;
        MemWrite = 2'b00;
        write_direction = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        write_direction = STA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL reset_status got=%h want=00000004", data_in); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_read_decode;
        @(posedge clk); #1;
        write_direction = TXA;
        @(negedge clk);
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL rd_txaddr got=%h want=00000000", data_in); end
        write_direction = 32'h0;
        @(negedge clk);
        total++; if (data_in !== 32'h0) begin bad++; $display("FAIL rd_zero got=%h want=00000000", data_in); end
        write_direction = STA;
        @(negedge clk);
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL rd_stat_idle got=%h want=00000004", data_in); end
        write_direction = 32'h0;
    endtask

    task automatic test_single;
        logic [9:0] fr;
        logic       exp;
        fr = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        do_write(TXA, 32'hFFFF_FFA5);
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL lat_edge1 got=%b want=1", tx); end
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL lat_edge2 got=%b want=1", tx); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            exp = fr[i/4];
            total++;
            if (tx !== exp) begin bad++; $display("FAIL a5_frame cyc=%0d got=%b want=%b", i, tx, exp); end
        end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL a5_busy_after got=%b want=0", tx_busy); end
        write_direction = STA;
        #1;
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL a5_status_after got=%h want=00000004", data_in); end
        write_direction = 32'h0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        logic [9:0] fr;
        logic       exp;
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
        @(posedge clk); #1;
        do_write(TXA, 32'h01);
        do_write(TXA, 32'h02);
        do_write(TXA, 32'h03);
        write_direction = STA;
        @(negedge clk);
        total++; if (data_in !== 32'h21) begin bad++; $display("FAIL b2b_count got=%h want=00000021", data_in); end
        for (int i = 0; i < 120; i++) begin
            if (i > 0) @(negedge clk);
            fr  = {1'b1, bytes[i/40], 1'b0};
            exp = fr[(i%40)/4];
            total++;
            if (tx !== exp) begin bad++; $display("FAIL b2b_frame cyc=%0d got=%b want=%b", i, tx, exp); end
        end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_after got=%b want=0", tx_busy); end
        write_direction = 32'h0;
    endtask

    task automatic test_overflow;
        int base;
        int n;
        base = tx_falls;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) do_write(TXA, 32'hFF);
        write_direction = STA;
        @(negedge clk);
        total++; if (data_in !== 32'h4B) begin bad++; $display("FAIL ovf_set got=%h want=0000004b", data_in); end
        @(posedge clk); #1;
        do_write(STA, 32'h0);
        write_direction = STA;
        @(negedge clk);
        total++; if (data_in !== 32'h43) begin bad++; $display("FAIL ovf_clear got=%h want=00000043", data_in); end
        n = 0;
        while (tx_busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ovf_drain_timeout got=%b want=0", tx_busy); end
        total++; if (tx_falls - base !== 5) begin bad++; $display("FAIL ovf_frames got=%0d want=5", tx_falls - base); end
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL ovf_final got=%h want=00000004", data_in); end
        write_direction = 32'h0;
    endtask

    task automatic test_full_pop;
        int base;
        int n;
        base = tx_falls;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) do_write(TXA, 32'hFF);
        repeat (36) @(posedge clk);
        #1;
        do_write(TXA, 32'hFF);
        write_direction = STA;
        @(negedge clk);
        total++; if (data_in !== 32'h43) begin bad++; $display("FAIL fullpop_status got=%h want=00000043", data_in); end
        n = 0;
        while (tx_busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL fullpop_timeout got=%b want=0", tx_busy); end
        total++; if (tx_falls - base !== 6) begin bad++; $display("FAIL fullpop_frames got=%0d want=6", tx_falls - base); end
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL fullpop_final got=%h want=00000004", data_in); end
        write_direction = 32'h0;
    endtask

    task automatic test_reset_mid;
        int base;
        int lows;
        @(posedge clk); #1;
        do_write(TXA, 32'h00);
        do_write(TXA, 32'h00);
        repeat (17) @(posedge clk);
        @(negedge clk);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre_reset got=%b want=0", tx); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        write_direction = STA;
        @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx_after got=%b want=1", tx); end
        total++; if (data_in !== 32'h4) begin bad++; $display("FAIL mid_status got=%h want=00000004", data_in); end
        base = tx_falls;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        total++; if (lows !== 0) begin bad++; $display("FAIL mid_quiet got=%0d want=0", lows); end
        total++; if (tx_falls - base !== 0) begin bad++; $display("FAIL mid_frames got=%0d want=0", tx_falls - base); end
        write_direction = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        MemWrite = 2'b00;
        write_direction = 32'h0;
        data_out1 = 32'h0;
        test_reset;
        test_read_decode;
        test_single;
        test_back_to_back;
        test_overflow;
        test_full_pop;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
